// File: rtl/row_drv_pkg.sv
// Shared encodings for the row burst driver: request modes and FSM states.
package row_drv_pkg;

  typedef enum logic [1:0] {
    MODE_WRITE = 2'b00,
    MODE_MAC   = 2'b01,
    MODE_CAM   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_GAP   = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/row_onehot_dec.sv
// Combinational row address to one-hot word-line decoder.
module row_onehot_dec
  import row_drv_pkg::*;
#(
  parameter int unsigned ROWS = 4,
  parameter int unsigned AW   = $clog2(ROWS)
) (
  input  logic [AW-1:0]   row_i,
  output logic [ROWS-1:0] onehot_c_o
);

  // One bit per row, set where the row index matches.
  always_comb begin
    onehot_c_o = '0;
    for (int unsigned i = 0; i < ROWS; i++) begin
      onehot_c_o[i] = (row_i == AW'(i));
    end
  end

endmodule

// File: rtl/row_burst_driver.sv
// Word-line controller for the CAM/MAC bit-cell array: WRITE, MAC bursts, CAM search.
// Optional build macro ROW_DRV_DUMMY_EN enables the dummy sensing row (WL_dummy).
module row_burst_driver
  import row_drv_pkg::*;
#(
  parameter int unsigned ROWS      = 4,
  parameter int unsigned AW        = $clog2(ROWS),
  parameter int unsigned PULSE_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic            read_bar,
  input  logic [AW-1:0]   addr,
  input  logic [AW:0]     burst_len,
  input  logic [ROWS-1:0] data,
  output logic            busy,
  output logic            done,
  output logic [AW-1:0]   row_idx,
  output logic [ROWS-1:0] WL,
  output logic [ROWS-1:0] WLB,
  output logic            WL_dummy
);

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(PULSE_CYC + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYC - 1);
  localparam logic [LW-1:0] ROWS_LEN   = LW'(ROWS);
  localparam logic [AW-1:0] LAST_ROW   = AW'(ROWS - 1);

  state_e          state_q, state_d;
  mode_e           mode_q, mode_d;
  logic            read_bar_q, read_bar_d;
  logic [AW-1:0]   row_q, row_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic [ROWS-1:0] data_q, data_d;
  logic [CW-1:0]   pcnt_q, pcnt_d;

  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [AW-1:0]   row_idx_q, row_idx_d;
  logic [ROWS-1:0] wl_q, wl_d;
  logic [ROWS-1:0] wlb_q, wlb_d;
  logic            dummy_q, dummy_d;

  logic [ROWS-1:0] onehot;
  logic [LW-1:0]   len_clamped;

  row_onehot_dec #(.ROWS(ROWS), .AW(AW)) u_dec (
    .row_i      (row_q),
    .onehot_c_o (onehot)
  );

  // MAC row count: zero means one row, anything past the array size saturates.
  always_comb begin
    len_clamped = burst_len;
    if (burst_len == '0) begin
      len_clamped = LW'(1);
    end else if (burst_len > ROWS_LEN) begin
      len_clamped = ROWS_LEN;
    end
  end

  // Next-state, request latching, pulse/row sequencing and line values for the current state.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    read_bar_d = read_bar_q;
    row_d      = row_q;
    rem_d      = rem_q;
    data_d     = data_q;
    pcnt_d     = pcnt_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    row_idx_d  = '0;
    wl_d       = '0;
    wlb_d      = '0;
    dummy_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start && cs && (mode_e'(mode) != MODE_RSVD)) begin
          mode_d     = mode_e'(mode);
          read_bar_d = read_bar;
          row_d      = addr;
          rem_d      = (mode_e'(mode) == MODE_MAC) ? len_clamped : LW'(1);
          data_d     = data;
          pcnt_d     = PULSE_LOAD;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (pcnt_q != '0) begin
          pcnt_d = pcnt_q - CW'(1);
        end else if ((mode_q == MODE_MAC) && (rem_q > LW'(1))) begin
          row_d   = (row_q == LAST_ROW) ? '0 : row_q + AW'(1);
          rem_d   = rem_q - LW'(1);
          state_d = ST_GAP;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_GAP: begin
        pcnt_d  = PULSE_LOAD;
        state_d = ST_DRIVE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Lines follow the current state one edge later; deselect forces everything low.
    if (cs) begin
      busy_d = (state_q != ST_IDLE);
      done_d = (state_q == ST_DONE);
      if (state_q == ST_DRIVE) begin
        unique case (mode_q)
          MODE_WRITE: begin
            row_idx_d = row_q;
            wl_d      = onehot;
            wlb_d     = onehot;
          end
          MODE_MAC: begin
            row_idx_d = row_q;
            if (read_bar_q) begin
              wlb_d = onehot;
            end else begin
              wl_d = onehot;
            end
          end
          MODE_CAM: begin
            wl_d  = data_q;
            wlb_d = ~data_q;
          end
          default: begin
            wl_d = '0;
          end
        endcase
`ifdef ROW_DRV_DUMMY_EN
        dummy_d = (mode_q != MODE_WRITE);
`else
        dummy_d = 1'b0;
`endif
      end
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_WRITE;
      read_bar_q <= 1'b0;
      row_q      <= '0;
      rem_q      <= '0;
      data_q     <= '0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      read_bar_q <= read_bar_d;
      row_q      <= row_d;
      rem_q      <= rem_d;
      data_q     <= data_d;
      pcnt_q     <= pcnt_d;
    end
  end

  // Registered outputs toward the analog word-line drivers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      row_idx_q <= '0;
      wl_q      <= '0;
      wlb_q     <= '0;
      dummy_q   <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      row_idx_q <= row_idx_d;
      wl_q      <= wl_d;
      wlb_q     <= wlb_d;
      dummy_q   <= dummy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign row_idx  = row_idx_q;
  assign WL       = wl_q;
  assign WLB      = wlb_q;
  assign WL_dummy = dummy_q;

endmodule

// File: tb/tb_row_burst_driver.sv
// Self-checking bench for row_burst_driver (ROWS=4, PULSE_CYC=2).
module tb_row_burst_driver;
  import row_drv_pkg::*;

  localparam int unsigned ROWS = 4;
  localparam int unsigned AW   = 2;
  localparam int unsigned LW   = AW + 1;
  localparam int unsigned P    = 2;

  logic            clk = 1'b0;
  logic            rst, cs, start, read_bar;
  logic [1:0]      mode;
  logic [AW-1:0]   addr;
  logic [LW-1:0]   burst_len;
  logic [ROWS-1:0] data;
  logic            busy, done, WL_dummy;
  logic [AW-1:0]   row_idx;
  logic [ROWS-1:0] WL, WLB;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic [AW-1:0]   row;
    logic [ROWS-1:0] wl;
    logic [ROWS-1:0] wlb;
    logic            dummy;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  row_burst_driver #(.ROWS(ROWS), .AW(AW), .PULSE_CYC(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .start     (start),
    .mode      (mode),
    .read_bar  (read_bar),
    .addr      (addr),
    .burst_len (burst_len),
    .data      (data),
    .busy      (busy),
    .done      (done),
    .row_idx   (row_idx),
    .WL        (WL),
    .WLB       (WLB),
    .WL_dummy  (WL_dummy)
  );

  // Expected per-cycle output trace of one accepted request, starting the cycle after start is sampled.
  function automatic void build_expect(input mode_e m, input int a, input int len,
                                       input logic rb, input logic [ROWS-1:0] d);
    int   n;
    int   r;
    obs_t e;
    exp_q.delete();
    n = 1;
    if (m == MODE_MAC) n = (len == 0) ? 1 : ((len > int'(ROWS)) ? int'(ROWS) : len);
    exp_q.push_back('0);
    for (int k = 0; k < n; k++) begin
      r = (a + k) % int'(ROWS);
      e = '0;
      e.busy = 1'b1;
      if (m == MODE_WRITE) begin
        e.row = AW'(r);
        e.wl  = ROWS'(1) << r;
        e.wlb = e.wl;
      end else if (m == MODE_MAC) begin
        e.row = AW'(r);
        if (rb) e.wlb = ROWS'(1) << r;
        else    e.wl  = ROWS'(1) << r;
      end else begin
        e.wl  = d;
        e.wlb = ~d;
      end
`ifdef ROW_DRV_DUMMY_EN
      e.dummy = (m != MODE_WRITE);
`endif
      for (int p = 0; p < int'(P); p++) exp_q.push_back(e);
      if (k < n - 1) begin
        e = '0;
        e.busy = 1'b1;
        exp_q.push_back(e);
      end
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    exp_q.push_back(e);
    exp_q.push_back('0);
  endfunction

  // One request through the driver; with noise, new start strobes are thrown in while it is busy.
  task automatic test_request(input string name, input mode_e m, input int a, input int len,
                              input logic rb, input logic [ROWS-1:0] d, input bit noise);
    obs_t o;
    obs_t e;
    build_expect(m, a, len, rb, d);
    @(negedge clk);
    start = 1'b1; mode = m; addr = AW'(a); burst_len = LW'(len); read_bar = rb; data = d;
    for (int j = 0; j < exp_q.size(); j++) begin
      @(negedge clk);
      o = {busy, done, row_idx, WL, WLB, WL_dummy};
      e = exp_q[j];
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL %s cyc%0d: got busy=%b done=%b row=%0d WL=%b WLB=%b dmy=%b, want busy=%b done=%b row=%0d WL=%b WLB=%b dmy=%b",
                 name, j, o.busy, o.done, o.row, o.wl, o.wlb, o.dummy,
                 e.busy, e.done, e.row, e.wl, e.wlb, e.dummy);
      end
      if (noise && (j + 2 < exp_q.size())) begin
        start = 1'($urandom); mode = 2'($urandom); addr = AW'($urandom);
        burst_len = LW'($urandom); read_bar = 1'($urandom); data = ROWS'($urandom);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    obs_t o;
    rst = 1'b1; cs = 1'b1; start = 1'b1; mode = MODE_WRITE; addr = '0;
    burst_len = '0; read_bar = 1'b0; data = '0;
    repeat (2) begin
      @(negedge clk);
      o = {busy, done, row_idx, WL, WLB, WL_dummy};
      checks++;
      if (o !== '0) begin errors++; $display("FAIL reset_hold: got %h want 0", o); end
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    o = {busy, done, row_idx, WL, WLB, WL_dummy};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_release: got %h want 0", o); end
    // Reset in the middle of a burst wins over a simultaneous start.
    start = 1'b1; mode = MODE_MAC; burst_len = LW'(4);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    o = {busy, done, row_idx, WL, WLB, WL_dummy};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL reset_midburst: got %h want 0", o); end
    rst = 1'b0; start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      o = {busy, done, row_idx, WL, WLB, WL_dummy};
      checks++;
      if (o !== '0) begin errors++; $display("FAIL reset_after: got %h want 0", o); end
    end
  endtask

  task automatic test_write();
    test_request("write_a2", MODE_WRITE, 2, 0, 1'b0, '0, 1'b0);
    test_request("write_a0", MODE_WRITE, 0, 5, 1'b1, 4'hF, 1'b0);
  endtask

  task automatic test_mac();
    test_request("mac_a3_l3", MODE_MAC, 3, 3, 1'b0, '0, 1'b0);
    test_request("mac_wrap", MODE_MAC, 3, 2, 1'b1, '0, 1'b0);
    test_request("mac_a1_l4_rb", MODE_MAC, 1, 4, 1'b1, '0, 1'b0);
  endtask

  task automatic test_cam();
    test_request("cam_1010", MODE_CAM, 0, 0, 1'b0, 4'b1010, 1'b0);
    test_request("cam_0011", MODE_CAM, 3, 7, 1'b1, 4'b0011, 1'b0);
  endtask

  task automatic test_abort();
    obs_t o;
    @(negedge clk);
    start = 1'b1; mode = MODE_MAC; addr = '0; burst_len = LW'(4); read_bar = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (row_idx !== AW'(1) || WL !== 4'b0010) begin
      errors++; $display("FAIL abort_row2: got row=%0d WL=%b want row=1 WL=0010", row_idx, WL);
    end
    cs = 1'b0;
    @(negedge clk);
    o = {busy, done, row_idx, WL, WLB, WL_dummy};
    checks++;
    if (o !== '0) begin errors++; $display("FAIL abort_lines: got %h want 0", o); end
    cs = 1'b1;
    repeat (4) begin
      @(negedge clk);
      o = {busy, done, row_idx, WL, WLB, WL_dummy};
      checks++;
      if (o !== '0) begin errors++; $display("FAIL abort_nodone: got %h want 0", o); end
    end
    // start while deselected is ignored.
    cs = 1'b0; start = 1'b1; mode = MODE_WRITE;
    repeat (3) begin
      @(negedge clk);
      o = {busy, done, row_idx, WL, WLB, WL_dummy};
      checks++;
      if (o !== '0) begin errors++; $display("FAIL cs_low_start: got %h want 0", o); end
    end
    start = 1'b0; cs = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_edge_cases();
    obs_t o;
    test_request("mac_len0", MODE_MAC, 2, 0, 1'b0, '0, 1'b0);
    test_request("mac_len7", MODE_MAC, 1, 7, 1'b0, '0, 1'b0);
    @(negedge clk);
    start = 1'b1; mode = MODE_RSVD; addr = AW'(1); burst_len = LW'(2);
    repeat (4) begin
      @(negedge clk);
      o = {busy, done, row_idx, WL, WLB, WL_dummy};
      checks++;
      if (o !== '0) begin errors++; $display("FAIL mode_rsvd: got %h want 0", o); end
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    test_request("busy_start_mac", MODE_MAC, 0, 4, 1'b0, '0, 1'b1);
    test_request("busy_start_cam", MODE_CAM, 0, 0, 1'b0, 4'b0110, 1'b1);
    test_request("busy_start_wr", MODE_WRITE, 3, 0, 1'b0, '0, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_request("random", mode_e'($urandom_range(0, 2)), int'($urandom_range(0, ROWS - 1)),
                   int'($urandom_range(0, 7)), 1'($urandom), ROWS'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_mac();
    test_cam();
    test_abort();
    test_edge_cases();
    test_start_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
